// File: rtl/inst_fetch_bridge_pkg.sv
// Shared constants and helpers for the instruction-fetch bridge.
// Optional one-entry hit buffer is enabled by FETCH_HIT_BUF_EN.
package inst_fetch_bridge_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [0:0] FETCH_IDLE = 1'b0;
  localparam logic [0:0] FETCH_WAIT = 1'b1;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  function automatic logic [INST_ADDR_W-1:0] word_addr(
    input logic [INST_ADDR_W-1:0] a
  );
    return a & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/inst_fetch_bridge_hit_buf.sv
// One-entry fetch buffer: valid, word tag and instruction data.
// Built into the bridge only when FETCH_HIT_BUF_EN is defined.
module fetch_hit_buf
  import inst_fetch_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_inval,
  input  logic [29:0]       i_tag,
  input  logic [INST_W-1:0] i_data,
  input  logic [29:0]       i_cmp_tag,
  output logic              o_hit,
  output logic [INST_W-1:0] o_data
);
  logic              r_valid;
  logic [29:0]       r_tag;
  logic [INST_W-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= NOP_INST;
    end else if (i_inval) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_tag   <= i_tag;
      r_data  <= i_data;
    end
  end

  assign o_hit  = r_valid && (r_tag == i_cmp_tag);
  assign o_data = r_data;
endmodule

// File: rtl/inst_fetch_bridge.sv
// Turns a req/ack instruction memory into a zero-wait ROM with stall.
// Define FETCH_HIT_BUF_EN to add a one-entry re-fetch buffer.
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rom_ce_i,
  input  logic [INST_ADDR_W-1:0] rom_addr_i,
  output logic [INST_W-1:0]      rom_data_o,
  output logic                   stallreq_o,
  output logic                   bus_req_o,
  output logic [INST_ADDR_W-1:0] bus_addr_o,
  input  logic                   bus_ack_i,
  input  logic [INST_W-1:0]      bus_rdata_i,
  output logic                   bus_err_o
);
  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [0:0]             r_state;
  logic [INST_ADDR_W-1:0] r_addr_q;
  logic [WAIT_W-1:0]      r_wait_cnt;
  logic                   r_err;

  logic [0:0]             w_state_nxt;
  logic [INST_ADDR_W-1:0] w_addr_nxt;
  logic [WAIT_W-1:0]      w_cnt_nxt;
  logic [INST_ADDR_W-1:0] w_bus_addr;
  logic [INST_W-1:0]      w_data;
  logic                   w_req;
  logic                   w_stall;
  logic                   w_tmo;
  logic                   w_hit;
  logic [INST_W-1:0]      w_buf_data;

`ifdef FETCH_HIT_BUF_EN
  logic w_load;
  assign w_load = w_req && bus_ack_i;

  fetch_hit_buf u_hit_buf (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_inval   (w_tmo),
    .i_tag     (w_bus_addr[31:2]),
    .i_data    (bus_rdata_i),
    .i_cmp_tag (rom_addr_i[31:2]),
    .o_hit     (w_hit),
    .o_data    (w_buf_data)
  );
`else
  assign w_hit      = 1'b0;
  assign w_buf_data = NOP_INST;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr_q;
    w_cnt_nxt   = r_wait_cnt;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_tmo       = 1'b0;
    w_data      = NOP_INST;
    w_bus_addr  = (r_state == FETCH_WAIT) ? r_addr_q
                                          : word_addr(rom_addr_i);
    if (!rst) begin
      unique case (1'b1)
        (r_state == FETCH_IDLE): begin
          if (rom_ce_i && w_hit) begin
            w_data = w_buf_data;
          end else if (rom_ce_i) begin
            w_req = 1'b1;
            if (bus_ack_i) begin
              w_data = bus_rdata_i;
            end else begin
              w_stall     = 1'b1;
              w_addr_nxt  = w_bus_addr;
              w_cnt_nxt   = WAIT_W'(1);
              w_state_nxt = FETCH_WAIT;
            end
          end
        end
        (r_state == FETCH_WAIT): begin
          w_req = 1'b1;
          // Ack wins over a timeout landing in the same cycle.
          if (bus_ack_i) begin
            w_data      = bus_rdata_i;
            w_cnt_nxt   = '0;
            w_state_nxt = FETCH_IDLE;
          end else if (r_wait_cnt == MAX_CNT) begin
            w_tmo       = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = FETCH_IDLE;
          end else begin
            w_stall   = 1'b1;
            w_cnt_nxt = r_wait_cnt + WAIT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH_IDLE;
      r_addr_q   <= '0;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr_q   <= w_addr_nxt;
      r_wait_cnt <= w_cnt_nxt;
      r_err      <= r_err | w_tmo;
    end
  end

  assign rom_data_o = w_data;
  assign stallreq_o = w_stall;
  assign bus_req_o  = w_req;
  assign bus_addr_o = w_bus_addr;
  assign bus_err_o  = r_err;
endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge (MAX_WAIT=4).
// Honours FETCH_HIT_BUF_EN for the re-fetch expectations.
module tb_inst_fetch_bridge;
  logic        clk;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        stallreq_o;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_o;

  int n_pass;
  int n_total;
  int n_req;

  inst_fetch_bridge #(.MAX_WAIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce_i    (rom_ce_i),
    .rom_addr_i  (rom_addr_i),
    .rom_data_o  (rom_data_o),
    .stallreq_o  (stallreq_o),
    .bus_req_o   (bus_req_o),
    .bus_addr_o  (bus_addr_o),
    .bus_ack_i   (bus_ack_i),
    .bus_rdata_i (bus_rdata_i),
    .bus_err_o   (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drv(input logic ce, input logic [31:0] a,
                     input logic ack, input logic [31:0] d);
    rom_ce_i    = ce;
    rom_addr_i  = a;
    bus_ack_i   = ack;
    bus_rdata_i = d;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    n_req   = 0;
    rst     = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 32'h0);
    #2;
    chk("rst_req", {31'h0, bus_req_o}, 32'h0);
    chk("rst_stall", {31'h0, stallreq_o}, 32'h0);
    chk("rst_data", rom_data_o, 32'h0);
    chk("rst_err", {31'h0, bus_err_o}, 32'h0);

    @(negedge clk); rst = 1'b0; #1;
    chk("idle_req", {31'h0, bus_req_o}, 32'h0);

    // zero-wait memory
    @(negedge clk); drv(1'b1, 32'h00, 1'b1, 32'h3401_0011); #1;
    chk("zw0_data", rom_data_o, 32'h3401_0011);
    chk("zw0_stall", {31'h0, stallreq_o}, 32'h0);
    chk("zw0_req", {31'h0, bus_req_o}, 32'h1);
    @(negedge clk); drv(1'b1, 32'h04, 1'b1, 32'h3402_0022); #1;
    chk("zw4_data", rom_data_o, 32'h3402_0022);
    chk("zw4_stall", {31'h0, stallreq_o}, 32'h0);
    chk("zw4_addr", bus_addr_o, 32'h04);
    @(negedge clk); drv(1'b1, 32'h08, 1'b1, 32'h0022_1820); #1;
    chk("zw8_data", rom_data_o, 32'h0022_1820);
    chk("zw8_stall", {31'h0, stallreq_o}, 32'h0);
    chk("zw8_req", {31'h0, bus_req_o}, 32'h1);

    // ack after three stall cycles
    @(negedge clk); drv(1'b1, 32'h10, 1'b0, 32'hDEAD_BEEF); #1;
    chk("w3_stall0", {31'h0, stallreq_o}, 32'h1);
    chk("w3_addr0", bus_addr_o, 32'h10);
    @(negedge clk); drv(1'b1, 32'h99, 1'b0, 32'hDEAD_BEEF); #1;
    chk("w3_stall1", {31'h0, stallreq_o}, 32'h1);
    chk("w3_addr1", bus_addr_o, 32'h10);
    @(negedge clk); drv(1'b1, 32'h10, 1'b0, 32'hDEAD_BEEF); #1;
    chk("w3_stall2", {31'h0, stallreq_o}, 32'h1);
    chk("w3_req2", {31'h0, bus_req_o}, 32'h1);
    @(negedge clk); drv(1'b1, 32'h10, 1'b1, 32'h3401_0001); #1;
    chk("w3_data", rom_data_o, 32'h3401_0001);
    chk("w3_stall3", {31'h0, stallreq_o}, 32'h0);
    chk("w3_addr3", bus_addr_o, 32'h10);
    @(negedge clk); drv(1'b0, 32'h14, 1'b0, 32'h0); #1;
    chk("w3_idle_req", {31'h0, bus_req_o}, 32'h0);

    // timeout at MAX_WAIT=4
    @(negedge clk); drv(1'b1, 32'h20, 1'b0, 32'h1111_1111); #1;
    chk("to_stall0", {31'h0, stallreq_o}, 32'h1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); #1;
      chk("to_stall_w", {31'h0, stallreq_o}, 32'h1);
    end
    @(negedge clk); #1;
    chk("to_data", rom_data_o, 32'h0);
    chk("to_stall", {31'h0, stallreq_o}, 32'h0);
    chk("to_req_last", {31'h0, bus_req_o}, 32'h1);
    chk("to_err_pre", {31'h0, bus_err_o}, 32'h0);
    @(negedge clk); drv(1'b0, 32'h20, 1'b1, 32'hFFFF_FFFF); #1;
    chk("to_err", {31'h0, bus_err_o}, 32'h1);
    chk("late_req", {31'h0, bus_req_o}, 32'h0);
    chk("late_data", rom_data_o, 32'h0);
    @(negedge clk); drv(1'b0, 32'h20, 1'b0, 32'h0); #1;
    chk("err_sticky", {31'h0, bus_err_o}, 32'h1);

    // async reset while waiting
    @(negedge clk); drv(1'b1, 32'h30, 1'b0, 32'h0); #1;
    chk("rw_stall0", {31'h0, stallreq_o}, 32'h1);
    @(negedge clk); #1;
    chk("rw_stall1", {31'h0, stallreq_o}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rw_req", {31'h0, bus_req_o}, 32'h0);
    chk("rw_stall", {31'h0, stallreq_o}, 32'h0);
    chk("rw_data", rom_data_o, 32'h0);
    chk("rw_err", {31'h0, bus_err_o}, 32'h0);
    @(negedge clk); rst = 1'b0; drv(1'b0, 32'h30, 1'b0, 32'h0); #1;
    chk("rw_idle_req", {31'h0, bus_req_o}, 32'h0);
    @(negedge clk); drv(1'b1, 32'h50, 1'b1, 32'h0000_5050); #1;
    chk("rw_idle_addr", bus_addr_o, 32'h50);
    chk("rw_idle_data", rom_data_o, 32'h0000_5050);

    // pc held at 0x40 for five cycles after the fetch
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drv(1'b1, 32'h40, 1'b1, 32'h0040_0093); #1;
      if (bus_req_o) n_req++;
      chk("hold_data", rom_data_o, 32'h0040_0093);
      chk("hold_stall", {31'h0, stallreq_o}, 32'h0);
    end
`ifdef FETCH_HIT_BUF_EN
    chk("hold_reqs", n_req, 32'd1);
`else
    chk("hold_reqs", n_req, 32'd6);
`endif

    // misaligned pc after evicting the buffer
    @(negedge clk); drv(1'b1, 32'h60, 1'b1, 32'h0060_0113); #1;
    chk("ev_data", rom_data_o, 32'h0060_0113);
    @(negedge clk); drv(1'b1, 32'h43, 1'b1, 32'h0040_0093); #1;
    chk("mis_addr", bus_addr_o, 32'h40);
    chk("mis_req", {31'h0, bus_req_o}, 32'h1);
    chk("mis_data", rom_data_o, 32'h0040_0093);

    @(negedge clk); drv(1'b0, 32'h0, 1'b0, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
